vga_window_scanout: RTL
=======================

// Module: vga_window_scanout
// PURPOSE
//   VGA 640x480@60Hz timing generator and scan-out stage downstream of the 256x256x3-bit VideoMemory.
//   Derives the 25 MHz pixel enable from the 50 MHz Clock.
//   Generates raster counters, sync pulses and the framebuffer read address.
//   Outputs registered RGB: the window pixel inside the centred 256x256 area, BORDER_COLOR elsewhere in the visible area, black in blanking.
// PARAMETERS
//   H_VISIBLE 640 visible columns; H_FRONT 16; H_SYNC 96; H_BACK 48 (line = 800 px)
//   V_VISIBLE 480 visible rows;    V_FRONT 10; V_SYNC 2;  V_BACK 33 (frame = 525 lines)
//   WIN_X 192  first window column; WIN_Y 112 first window row (window is always 256x256)
//   BORDER_COLOR 3'b000  {R,G,B} shown in visible area outside the window
// PORTS
//   Clock             in   1   50 MHz system clock
//   Reset             in   1   synchronous, active-high
//   iColorFromMemory  in   3   {R,G,B} from VideoMemory, registered read (valid 1 Clock after address)
//   oReadAddress      out  16  VideoMemory read address = {winRow[7:0], winCol[7:0]}
//   oCurrentRow       out  10  vertical counter, 0..524
//   oCurrentCol       out  10  horizontal counter, 0..799
//   oVGA_HSync        out  1   active-low horizontal sync
//   oVGA_VSync        out  1   active-low vertical sync
//   oVGA_R/oVGA_G/oVGA_B out 1 each   colour bits
//   oFrameStart       out  1   one-Clock pulse at start of each frame
// BEHAVIOUR
//   Reset (synchronous): rPixelEn=0, Col=0, Row=0, oVGA_HSync=1, oVGA_VSync=1, RGB=0, oFrameStart=0; also when asserted mid-frame.
//   Pixel enable:
//     - rPixelEn toggles every Clock, so it is high on alternate edges (first high edge = 2nd edge after Reset release).
//     - All counters and video outputs update only on edges where rPixelEn==1.
//     - One pixel period = 2 Clocks.
//   Counters:
//     - Col increments 0..799 then wraps to 0.
//     - Row increments only when Col wraps, 0..524 then wraps to 0.
//   Window membership (from current counters): inWin = Col in [WIN_X, WIN_X+255] && Row in [WIN_Y, WIN_Y+255].
//     - Upper bounds inclusive, so exactly 256 px per side.
//   oReadAddress:
//     - Combinational from counters: {(Row-WIN_Y)[7:0], (Col-WIN_X)[7:0]} when inWin, else 16'h0000.
//     - Stable for the full pixel period.
//   Memory latency: data for the address is valid on the second Clock of the pixel period, before the next pixel-enable edge.
//   Output pipeline: on each pixel-enable edge, register from the pre-edge Row/Col and iColorFromMemory:
//     - oVGA_HSync = !(Col in [656,751])
//     - oVGA_VSync = !(Row in [490,491])
//     - RGB = inWin ? iColorFromMemory : (Col<640 && Row<480) ? BORDER_COLOR : 3'b000
//     - Result: sync and colour are mutually aligned and lag oCurrentRow/oCurrentCol by exactly one pixel period (2 Clocks).
//   oFrameStart:
//     - High for exactly one Clock, on the edge where Col wraps 799->0 and Row wraps 524->0 together.
//     - No pulse is generated by Reset itself.
//   Sync edges use the same pipelined compare, so HSync/VSync widths are exactly 96 px / 2 lines.
//   No back-pressure: the block free-runs and never stalls.
//   VideoMemory writes during scan-out are permitted; the displayed value is whatever the read returns (no tearing protection).
// TESTING
//   T1 Reset held 5 Clocks, then released:
//      -> all outputs at reset values; Col first becomes 1 on the 2nd edge after release, then advances every 2 Clocks.
//   T2 Run 1 line:
//      -> Col wraps 799->0 after 1600 Clocks, Row 0->1.
//      -> oVGA_HSync low for exactly 192 Clocks, falling 2 Clocks after Col becomes 656.
//   T3 Run 1 full frame (840000 Clocks):
//      -> oFrameStart pulses once, 1 Clock wide.
//      -> oVGA_VSync low for exactly 2 lines (3200 Clocks), starting at Row 490.
//   T4 Memory model returns colour = address[2:0]:
//      -> at Row=112,Col=192: oReadAddress=16'h0000; RGB=3'b000 two Clocks later.
//      -> at Row=367,Col=447: oReadAddress=16'hFFFF; RGB=3'b111.
//      -> at Col=448: RGB=BORDER_COLOR.
//   T5 BORDER_COLOR=3'b101, memory returns 3'b010:
//      -> Row=10,Col=10: RGB=101; Row=200,Col=300: RGB=010; Col=700 (blanking): RGB=000, oReadAddress=0.
//   T6 Assert Reset at Row=300,Col=400 for 1 Clock:
//      -> next edge counters=0,0, syncs=1, RGB=0; timing restarts as in T1 with no oFrameStart pulse.

Source files
------------

// File: rtl/vga_window_scanout.sv
// VGA raster generator and scan-out stage for a centred 256x256x3-bit window.
// Pixel rate is Clock/2. Sync and colour are registered one pixel period behind the counters.
module vga_window_scanout #(
  parameter int         H_VISIBLE    = 640,
  parameter int         H_FRONT      = 16,
  parameter int         H_SYNC       = 96,
  parameter int         H_BACK       = 48,
  parameter int         V_VISIBLE    = 480,
  parameter int         V_FRONT      = 10,
  parameter int         V_SYNC       = 2,
  parameter int         V_BACK       = 33,
  parameter int         WIN_X        = 192,
  parameter int         WIN_Y        = 112,
  parameter logic [2:0] BORDER_COLOR = 3'b000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  iColorFromMemory,
  output logic [15:0] oReadAddress,
  output logic [9:0]  oCurrentRow,
  output logic [9:0]  oCurrentCol,
  output logic        oVGA_HSync,
  output logic        oVGA_VSync,
  output logic        oVGA_R,
  output logic        oVGA_G,
  output logic        oVGA_B,
  output logic        oFrameStart
);

  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] WX_FIRST  = 10'(WIN_X);
  localparam logic [9:0] WX_LAST   = 10'(WIN_X + 255);
  localparam logic [9:0] WY_FIRST  = 10'(WIN_Y);
  localparam logic [9:0] WY_LAST   = 10'(WIN_Y + 255);
  localparam logic [7:0] WX_LOW    = 8'(WIN_X);
  localparam logic [7:0] WY_LOW    = 8'(WIN_Y);

  logic       pixelEn;
  logic [9:0] col;
  logic [9:0] row;
  logic       inWin;
  logic       inVisible;
  logic [7:0] winCol;
  logic [7:0] winRow;
  logic       hSync;
  logic       vSync;
  logic [2:0] rgb;
  logic       frameStart;

  // The low byte of (counter - origin) equals the difference of the low bytes,
  // so the window offsets are formed directly in 8 bits.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    oReadAddress = 16'h0000;
    inWin     = (col >= WX_FIRST) && (col <= WX_LAST) && (row >= WY_FIRST) && (row <= WY_LAST);
    inVisible = (col < H_VIS_END) && (row < V_VIS_END);
    winCol    = col[7:0] - WX_LOW;
    winRow    = row[7:0] - WY_LOW;
    if (inWin) begin
      oReadAddress = {winRow, winCol};
    end
  end

  // NOTE: Reset is sampled on the clock edge only; it is not in the sensitivity list.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pixelEn    <= 1'b0;
      col        <= '0;
      row        <= '0;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      rgb        <= 3'b000;
      frameStart <= 1'b0;
    end else begin
      pixelEn    <= ~pixelEn;
      frameStart <= 1'b0;
      if (pixelEn) begin
        // Registered from the pre-edge counters: one pixel period of latency,
        // which also covers the one-Clock read latency of the video memory.
        hSync <= !((col >= HS_FIRST) && (col <= HS_LAST));
        vSync <= !((row >= VS_FIRST) && (row <= VS_LAST));
        if (inWin) begin
          rgb <= iColorFromMemory;
        end else if (inVisible) begin
          rgb <= BORDER_COLOR;
        end else begin
          rgb <= 3'b000;
        end

        if (col == H_LAST) begin
          col <= '0;
          if (row == V_LAST) begin
            row        <= '0;
            frameStart <= 1'b1;
          end else begin
            row <= row + 10'd1;
          end
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  assign oCurrentRow = row;
  assign oCurrentCol = col;
  assign oVGA_HSync  = hSync;
  assign oVGA_VSync  = vSync;
  assign oVGA_R      = rgb[2];
  assign oVGA_G      = rgb[1];
  assign oVGA_B      = rgb[0];
  assign oFrameStart = frameStart;

endmodule
